axis_video_decimator: RTL and testbench
=======================================

# axis_video_decimator

Parametrised AXI4-Stream video decimator: keeps every Hth pixel of every Vth line, with both H and V set per frame at run time. It sits between a video source (TPG or sensor path) and downstream video IP, and regenerates tuser/tlast framing for the reduced frame. A built-in monitor reports the measured output width and height and the number of completed frames, which a bench or software can compare against the configuration.

## Interface
- DATA_WIDTH, 24, pixel width in bits (tdata).
- FACTOR_WIDTH, 4, width of the decimation factor inputs; valid factors are 1..2^FACTOR_WIDTH-1.
- STAT_WIDTH, 16, width of the monitor counters.
- aclk  in  1  single clock for all logic.
- aresetn  in  1  reset; asynchronous, active-low.
- s_axis_tdata  in  DATA_WIDTH  input pixel.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted.
- s_axis_tuser  in  1  start of frame (SOF).
- s_axis_tlast  in  1  end of line (EOL).
- m_axis_tdata  out  DATA_WIDTH  output pixel.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tuser  out  1  output SOF.
- m_axis_tlast  out  1  output EOL.
- cfg_h_factor  in  FACTOR_WIDTH  horizontal decimation factor; 0 is treated as 1.
- cfg_v_factor  in  FACTOR_WIDTH  vertical decimation factor; 0 is treated as 1.
- stat_width  out  STAT_WIDTH  pixel count of the last output line.
- stat_height  out  STAT_WIDTH  line count of the last completed output frame.
- stat_frames  out  STAT_WIDTH  number of completed frames; wraps at the counter width.
- stat_early_sof  out  1  sticky flag: SOF arrived in the middle of a line.

## Operation
**Factor latching**
- h_f and v_f are latched from the cfg inputs on each accepted beat with s_axis_tuser=1.
- The latched values take effect starting with that beat.

**Counters**
- hcnt counts 0..h_f-1 per accepted beat. It clears on an accepted EOL or SOF.
- vcnt counts 0..v_f-1 per accepted EOL. It clears on an accepted SOF.
- A pixel is kept when hcnt==0 and vcnt==0. All other pixels are accepted and dropped.
- The first pixel of every kept line is always kept.

**Pending register P and output register O**
- P holds the most recent kept pixel. Flags: p_valid, p_user, p_last.
- O drives the m_axis outputs.
- Kept beat X without EOL:
  - If p_valid, P moves to O with tlast=0.
  - X is then loaded into P.
- Kept beat X with EOL:
  - If p_valid, P moves to O with tlast=0.
  - X is loaded into P with p_last=1.
- Dropped beat with EOL on a kept line: P moves to O with tlast=1, and P empties.
- p_last=1: P moves to O with tlast=1 at the next free O slot.
- Early SOF (p_valid=1 and the line is unfinished):
  - P moves to O with tlast=1.
  - The SOF beat loads P.
  - stat_early_sof is set and stays set until reset.
- The output tuser is the tuser of the pixel moved from P.

**Handshake and move rules**
- s_axis_tready = aresetn && !p_last && (!m_axis_tvalid || m_axis_tready).
- A move into O happens only when O is empty or is being drained in the same cycle.

**Monitor**
- On each output beat with tlast (valid && ready): stat_width <= line pixel count.
- On each output beat with tuser, when it is not the first SOF after reset:
  - stat_height <= line count of the previous frame.
  - stat_frames increments.

**Arithmetic and width rules**
- Counters are unsigned.
- Line and pixel counters saturate at 2^STAT_WIDTH-1.

## Timing
- Reset values: every m_axis output, every stat output, s_axis_tready, and all internal flags are 0.
- Reset mid-operation: P and O contents are discarded and no partial beat is emitted.
- After reset, the first output frame begins at the next input SOF.
- Latency:
  - A non-final kept pixel appears on m_axis in the cycle after the next kept pixel, or after the EOL beat, is accepted.
  - An EOL-kept pixel is accepted at edge k and is valid on m_axis after edge k+1.
- Throughput (m_axis_tready=1):
  - One beat per clock.
  - One input bubble per line when the EOL pixel is kept (p_last stall).
- While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, tuser and tlast are held stable.
- Simultaneous events on one beat:
  - SOF with EOL (a one-pixel line) follows the kept-EOL rule.
  - SOF has priority for counter clears.

## Test plan
- h=2, v=1, 480x640 input frame, m_axis_tready=1 -> 240 pixels per line, tlast on every 240th beat, tuser on the first beat. After the second SOF: stat_width=240, stat_height=640, stat_frames=1.
- h=3, width 10 -> pixels 0,3,6,9 output, tlast on pixel 9 (kept-EOL path). Width 11 -> same 4 pixels, tlast on pixel 9 (dropped-EOL path).
- v=2, 8x5 frame, h=1 -> input lines 0,2,4 output, 8 pixels each; stat_height=3.
- Random 50% m_axis_tready with h=2, v=2 -> output sequence identical to the tready=1 run, no loss or duplication, data stable while stalled.
- cfg_h_factor changed 2->4 mid-frame -> the change has no effect until the next SOF. cfg_h_factor=0 -> output identical to h=1.
- SOF injected at pixel 5 of a line -> pending pixel is emitted with tlast=1, stat_early_sof=1, new frame correct. Reset asserted mid-line -> all outputs 0; the next frame is clean.

Source files
------------

// File: rtl/axis_video_decimator.sv
// axis_video_decimator
// AXI4-Stream video decimator. Keeps every Hth pixel of every Vth line, with
// H and V latched at each start of frame. Framing (tuser/tlast) is regenerated
// for the reduced frame through a one-pixel pending stage (P) feeding the
// output register (O). A monitor reports the measured output geometry and a
// completed-frame count.

module axis_video_decimator #(
   parameter int DATA_WIDTH   = 24,
   parameter int FACTOR_WIDTH = 4,
   parameter int STAT_WIDTH   = 16
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tuser,
   input  logic                    s_axis_tlast,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tuser,
   output logic                    m_axis_tlast,
   input  logic [FACTOR_WIDTH-1:0] cfg_h_factor,
   input  logic [FACTOR_WIDTH-1:0] cfg_v_factor,
   output logic [STAT_WIDTH-1:0]   stat_width,
   output logic [STAT_WIDTH-1:0]   stat_height,
   output logic [STAT_WIDTH-1:0]   stat_frames,
   output logic                    stat_early_sof
);

   localparam logic [FACTOR_WIDTH-1:0] F_ZERO = {FACTOR_WIDTH{1'b0}};
   localparam logic [FACTOR_WIDTH-1:0] F_ONE  = {{(FACTOR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [STAT_WIDTH-1:0]   S_ZERO = {STAT_WIDTH{1'b0}};
   localparam logic [STAT_WIDTH-1:0]   S_ONE  = {{(STAT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [STAT_WIDTH-1:0]   S_MAX  = {STAT_WIDTH{1'b1}};

   // A factor of zero behaves as one (keep everything)
   function automatic logic [FACTOR_WIDTH-1:0] fix_factor(input logic [FACTOR_WIDTH-1:0] f);
      return (f == F_ZERO) ? F_ONE : f;
   endfunction

   // Saturating increment for the monitor counters
   function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
      return (v == S_MAX) ? S_MAX : (v + S_ONE);
   endfunction

   // Latched factors, position counters, framing state
   logic [FACTOR_WIDTH-1:0] r_h_f, r_v_f, r_hcnt, r_vcnt;
   logic                    r_in_frame;
   // Pending register P
   logic [DATA_WIDTH-1:0]   r_p_data;
   logic                    r_p_valid, r_p_user, r_p_last;
   // Output register O
   logic [DATA_WIDTH-1:0]   r_o_data;
   logic                    r_o_valid, r_o_user, r_o_last;
   // Monitor
   logic [STAT_WIDTH-1:0]   r_pix_cnt, r_line_cnt;
   logic [STAT_WIDTH-1:0]   r_stat_width, r_stat_height, r_stat_frames;
   logic                    r_seen_sof, r_early_sof;

   logic                    w_o_free, w_s_ready, w_acc, w_keep, w_fire;
   logic [FACTOR_WIDTH-1:0] w_hf_eff, w_vf_eff, w_hcnt_cur, w_vcnt_cur;
   logic [FACTOR_WIDTH-1:0] w_hcnt_nxt, w_vcnt_nxt;
   logic                    w_move, w_move_last, w_load_p, w_clear_p, w_set_early;

   assign w_o_free   = !r_o_valid || m_axis_tready;
   assign w_s_ready  = aresetn && !r_p_last && w_o_free;
   assign w_acc      = s_axis_tvalid && w_s_ready;
   assign w_fire     = r_o_valid && m_axis_tready;

   // An SOF beat uses the new factors and starts at position (0,0)
   assign w_hf_eff   = s_axis_tuser ? fix_factor(cfg_h_factor) : r_h_f;
   assign w_vf_eff   = s_axis_tuser ? fix_factor(cfg_v_factor) : r_v_f;
   assign w_hcnt_cur = s_axis_tuser ? F_ZERO : r_hcnt;
   assign w_vcnt_cur = s_axis_tuser ? F_ZERO : r_vcnt;
   assign w_keep     = (s_axis_tuser || r_in_frame) &&
                       (w_hcnt_cur == F_ZERO) && (w_vcnt_cur == F_ZERO);

   // Next column/line position after the current beat
   always_comb begin
      w_hcnt_nxt = w_hcnt_cur;
      w_vcnt_nxt = w_vcnt_cur;
      if (s_axis_tlast) begin
         w_hcnt_nxt = F_ZERO;
         w_vcnt_nxt = (w_vcnt_cur == (w_vf_eff - F_ONE)) ? F_ZERO : (w_vcnt_cur + F_ONE);
      end else begin
         w_hcnt_nxt = (w_hcnt_cur == (w_hf_eff - F_ONE)) ? F_ZERO : (w_hcnt_cur + F_ONE);
         w_vcnt_nxt = w_vcnt_cur;
      end
   end

   // Decide P/O traffic for this cycle
   always_comb begin
      w_move      = 1'b0;
      w_move_last = 1'b0;
      w_load_p    = 1'b0;
      w_clear_p   = 1'b0;
      w_set_early = 1'b0;
      if (w_acc) begin
         if (w_keep) begin
            // P is never p_last here (input stalls), so a valid P at SOF
            // means the previous line was cut short.
            w_load_p = 1'b1;
            if (r_p_valid) begin
               w_move      = 1'b1;
               w_move_last = s_axis_tuser;
               w_set_early = s_axis_tuser;
            end else begin
               w_move = 1'b0;
            end
         end else if (s_axis_tlast && r_p_valid) begin
            // EOL dropped: the pending pixel closes the line
            w_move      = 1'b1;
            w_move_last = 1'b1;
            w_clear_p   = 1'b1;
         end else begin
            w_move = 1'b0;
         end
      end else if (r_p_last && w_o_free) begin
         // Kept EOL pixel leaves P on the first free output slot
         w_move      = 1'b1;
         w_move_last = 1'b1;
         w_clear_p   = 1'b1;
      end else begin
         w_move = 1'b0;
      end
   end

   // Factor latches, position counters and frame-open flag
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_h_f      <= F_ONE;
         r_v_f      <= F_ONE;
         r_hcnt     <= F_ZERO;
         r_vcnt     <= F_ZERO;
         r_in_frame <= 1'b0;
      end else if (w_acc) begin
         if (s_axis_tuser) begin
            r_h_f      <= w_hf_eff;
            r_v_f      <= w_vf_eff;
            r_in_frame <= 1'b1;
         end
         r_hcnt <= w_hcnt_nxt;
         r_vcnt <= w_vcnt_nxt;
      end
   end

   // Pending register P and sticky early-SOF flag
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_p_data    <= {DATA_WIDTH{1'b0}};
         r_p_valid   <= 1'b0;
         r_p_user    <= 1'b0;
         r_p_last    <= 1'b0;
         r_early_sof <= 1'b0;
      end else begin
         if (w_load_p) begin
            r_p_data  <= s_axis_tdata;
            r_p_valid <= 1'b1;
            r_p_user  <= s_axis_tuser;
            r_p_last  <= s_axis_tlast;
         end else if (w_clear_p) begin
            r_p_valid <= 1'b0;
            r_p_user  <= 1'b0;
            r_p_last  <= 1'b0;
         end
         if (w_set_early) begin
            r_early_sof <= 1'b1;
         end
      end
   end

   // Output register O; contents held while stalled
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_o_data  <= {DATA_WIDTH{1'b0}};
         r_o_valid <= 1'b0;
         r_o_user  <= 1'b0;
         r_o_last  <= 1'b0;
      end else if (w_move) begin
         r_o_data  <= r_p_data;
         r_o_valid <= 1'b1;
         r_o_user  <= r_p_user;
         r_o_last  <= w_move_last;
      end else if (m_axis_tready) begin
         r_o_valid <= 1'b0;
      end
   end

   // Monitor: measure lines and frames from the output handshakes
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_pix_cnt     <= S_ZERO;
         r_line_cnt    <= S_ZERO;
         r_stat_width  <= S_ZERO;
         r_stat_height <= S_ZERO;
         r_stat_frames <= S_ZERO;
         r_seen_sof    <= 1'b0;
      end else if (w_fire) begin
         if (r_o_last) begin
            r_stat_width <= sat_inc(r_pix_cnt);
            r_pix_cnt    <= S_ZERO;
         end else begin
            r_pix_cnt <= sat_inc(r_pix_cnt);
         end
         if (r_o_user) begin
            if (r_seen_sof) begin
               r_stat_height <= r_line_cnt;
               r_stat_frames <= r_stat_frames + S_ONE;
            end
            r_seen_sof <= 1'b1;
            r_line_cnt <= r_o_last ? S_ONE : S_ZERO;
         end else if (r_o_last) begin
            r_line_cnt <= sat_inc(r_line_cnt);
         end
      end
   end

   assign s_axis_tready  = w_s_ready;
   assign m_axis_tdata   = r_o_data;
   assign m_axis_tvalid  = r_o_valid;
   assign m_axis_tuser   = r_o_user;
   assign m_axis_tlast   = r_o_last;
   assign stat_width     = r_stat_width;
   assign stat_height    = r_stat_height;
   assign stat_frames    = r_stat_frames;
   assign stat_early_sof = r_early_sof;

endmodule

// File: tb/tb_axis_video_decimator.sv
// Bench for axis_video_decimator: frame-level reference model plus a
// per-cycle output comparator, with literal checks of monitor values.

module tb_axis_video_decimator;

   localparam int DW = 24;
   localparam int FW = 4;
   localparam int SW = 16;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic [DW-1:0] s_tdata = '0;
   logic          s_tvalid = 1'b0, s_tready, s_tuser = 1'b0, s_tlast = 1'b0;
   logic [DW-1:0] m_tdata;
   logic          m_tvalid, m_tready = 1'b1, m_tuser, m_tlast;
   logic [FW-1:0] cfg_h = 4'd1, cfg_v = 4'd1;
   logic [SW-1:0] st_w, st_h, st_f;
   logic          st_e;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          u;
      logic          l;
   } beat_t;

   beat_t exp_q[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    rdy_mode = 0;

   axis_video_decimator #(.DATA_WIDTH(DW), .FACTOR_WIDTH(FW), .STAT_WIDTH(SW)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
      .cfg_h_factor(cfg_h), .cfg_v_factor(cfg_v),
      .stat_width(st_w), .stat_height(st_h), .stat_frames(st_f),
      .stat_early_sof(st_e)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   function automatic logic [DW-1:0] pix(input int fid, input int y, input int x);
      logic [3:0] f4 = fid[3:0];
      logic [9:0] y10 = y[9:0];
      logic [9:0] x10 = x[9:0];
      return {f4, y10, x10};
   endfunction

   // Reference: kept lines are y%V==0, kept pixels x%H==0; first kept pixel of the
   // frame carries tuser, last kept pixel of each (possibly truncated) line tlast.
   task automatic model_frame(input int fid, input int w, input int lines,
                              input int hc, input int vc, input int trunc);
      int    hf = (hc == 0) ? 1 : hc;
      int    vf = (vc == 0) ? 1 : vc;
      bit    first = 1'b1;
      beat_t b;
      for (int y = 0; y < lines; y++) begin
         if (y % vf == 0) begin
            int n = (trunc >= 0 && y == lines - 1) ? trunc : w;
            int lastx = ((n - 1) / hf) * hf;
            for (int x = 0; x < n; x += hf) begin
               b.d = pix(fid, y, x);
               b.u = first;
               b.l = (x == lastx);
               exp_q.push_back(b);
               first = 1'b0;
            end
         end
      end
   endtask

   // Drive one input beat and wait until it is accepted
   task automatic put(input logic [DW-1:0] d, input logic u, input logic l);
      int n = 0;
      @(negedge aclk);
      s_tdata  = d;
      s_tuser  = u;
      s_tlast  = l;
      s_tvalid = 1'b1;
      forever begin
         #1;
         if (s_tready) begin
            @(posedge aclk);
            #1;
            break;
         end
         n++;
         if (n > 1000) begin
            chk("accept_timeout", 32'd0, 32'd1);
            break;
         end
         @(negedge aclk);
      end
   endtask

   task automatic send_frame(input int fid, input int w, input int lines, input int hc,
                             input int vc, input int trunc, input int chg_line, input int chg_h);
      cfg_h = hc[FW-1:0];
      cfg_v = vc[FW-1:0];
      for (int y = 0; y < lines; y++) begin
         bit cut = (trunc >= 0 && y == lines - 1);
         int n = cut ? trunc : w;
         if (y == chg_line) cfg_h = chg_h[FW-1:0];
         for (int x = 0; x < n; x++)
            put(pix(fid, y, x), (x == 0 && y == 0), (x == w - 1) && !cut);
      end
      @(negedge aclk);
      s_tvalid = 1'b0;
      s_tuser  = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(posedge aclk);
         n++;
      end
      chk(nm, exp_q.size(), 32'd0);
      repeat (3) @(posedge aclk);
      #1;
   endtask

   task automatic chk_stats(input string nm, input int w, input int h, input int f, input int e);
      chk({nm, "_width"}, st_w, w);
      chk({nm, "_height"}, st_h, h);
      chk({nm, "_frames"}, st_f, f);
      chk({nm, "_early"}, st_e, e);
   endtask

   // Downstream ready pattern
   initial begin
      forever begin
         @(negedge aclk);
         m_tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
   end

   // Output comparator: every handshake against the model, hold while stalled
   initial begin
      beat_t e;
      beat_t prev = '0;
      bit    prev_stall = 1'b0;
      forever begin
         @(negedge aclk);
         #2;
         if (prev_stall) begin
            chk("hold_valid", m_tvalid, 32'd1);
            chk("hold_beat", {m_tdata, m_tuser, m_tlast}, prev);
         end
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL extra_beat: got %0h expected none", m_tdata);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", m_tdata, e.d);
               chk("out_user", m_tuser, e.u);
               chk("out_last", m_tlast, e.l);
            end
         end
         prev_stall = m_tvalid && !m_tready;
         prev = {m_tdata, m_tuser, m_tlast};
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      beat_t b;
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_tvalid", m_tvalid, 32'd0);
      chk("rst_tdata", m_tdata, 32'd0);
      chk("rst_tready", s_tready, 32'd0);
      chk_stats("rst", 0, 0, 0, 0);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;

      // Literal pins of the reference model
      model_frame(1, 10, 1, 3, 1, -1);
      chk("model_h3_count", exp_q.size(), 32'd4);
      b = exp_q[3];
      chk("model_h3_lastpix", {b.d, b.u, b.l}, {24'h100009, 1'b0, 1'b1});
      b = exp_q[0];
      chk("model_h3_first", {b.u, b.l}, 32'd2);
      exp_q.delete();
      model_frame(2, 8, 3, 2, 1, 5);
      chk("model_trunc_count", exp_q.size(), 32'd11);
      b = exp_q[10];
      chk("model_trunc_last", {b.d, b.l}, {24'h200804, 1'b1});
      exp_q.delete();

      // A: 48x16, h=2
      model_frame(1, 48, 16, 2, 1, -1);  send_frame(1, 48, 16, 2, 1, -1, -1, 0);
      drain("drain_A");  chk_stats("A", 24, 0, 0, 0);
      // B: width 10, h=3, kept EOL
      model_frame(2, 10, 2, 3, 1, -1);   send_frame(2, 10, 2, 3, 1, -1, -1, 0);
      drain("drain_B");  chk_stats("B", 4, 16, 1, 0);
      // C: width 11, h=3, dropped EOL
      model_frame(3, 11, 2, 3, 1, -1);   send_frame(3, 11, 2, 3, 1, -1, -1, 0);
      drain("drain_C");  chk_stats("C", 4, 2, 2, 0);
      // D: 8x5, v=2
      model_frame(4, 8, 5, 1, 2, -1);    send_frame(4, 8, 5, 1, 2, -1, -1, 0);
      drain("drain_D");  chk_stats("D", 8, 2, 3, 0);
      // E: random downstream ready, h=2 v=2
      rdy_mode = 1;
      model_frame(5, 12, 6, 2, 2, -1);   send_frame(5, 12, 6, 2, 2, -1, -1, 0);
      drain("drain_E");
      rdy_mode = 0;
      repeat (2) @(posedge aclk);
      #1;
      chk_stats("E", 6, 3, 4, 0);
      // F: cfg_h 2->4 mid-frame, no effect until next SOF
      model_frame(6, 12, 4, 2, 1, -1);   send_frame(6, 12, 4, 2, 1, -1, 1, 4);
      drain("drain_F");  chk_stats("F", 6, 3, 5, 0);
      // G: factors 0 behave as 1
      model_frame(7, 6, 3, 0, 0, -1);    send_frame(7, 6, 3, 0, 0, -1, -1, 0);
      drain("drain_G");  chk_stats("G", 6, 4, 6, 0);
      // H: SOF arrives after pixel 4 of line 2; I: following clean frame
      model_frame(8, 8, 3, 2, 1, 5);     send_frame(8, 8, 3, 2, 1, 5, -1, 0);
      model_frame(9, 8, 2, 2, 1, -1);    send_frame(9, 8, 2, 2, 1, -1, -1, 0);
      drain("drain_HI"); chk_stats("I", 4, 3, 8, 1);

      // J: reset in the middle of line 1
      model_frame(10, 8, 2, 1, 1, 4);    send_frame(10, 8, 2, 1, 1, 4, -1, 0);
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_pending_left", exp_q.size(), 32'd1);
      aresetn = 1'b0;
      #1;
      chk("mid_rst_tvalid", m_tvalid, 32'd0);
      chk("mid_rst_beat", {m_tdata, m_tuser, m_tlast}, 32'd0);
      chk("mid_rst_tready", s_tready, 32'd0);
      chk_stats("mid_rst", 0, 0, 0, 0);
      exp_q.delete();
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      // Beats before the first SOF are discarded
      put(24'hABCDEF, 1'b0, 1'b0);
      put(24'h123456, 1'b0, 1'b0);
      put(24'h654321, 1'b0, 1'b1);
      model_frame(11, 6, 2, 1, 1, -1);   send_frame(11, 6, 2, 1, 1, -1, -1, 0);
      model_frame(12, 4, 1, 1, 1, -1);   send_frame(12, 4, 1, 1, 1, -1, -1, 0);
      drain("drain_KL"); chk_stats("L", 4, 2, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
